// File: rtl/lt24_screen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lt24_screen_pkg
//  Description : Shared colours, state encodings and a clog2 helper for the
//                LT24 screen controllers.
//  Revision    : 1.0 - initial release
// ============================================================================
package lt24_screen_pkg;

    localparam logic [15:0] RGB565_BLACK = 16'h0000;
    localparam logic [15:0] RGB565_WHITE = 16'hFFFF;

    typedef enum logic [1:0] {
        PX_FETCH = 2'd0,
        PX_WAIT  = 2'd1,
        PX_WRITE = 2'd2
    } px_state_e;

    typedef enum logic {
        MODE_IDLE    = 1'b0,
        MODE_VERDICT = 1'b1
    } mode_state_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lt24_raster_counter.sv
`default_nettype none
// ============================================================================
//  Module      : lt24_raster_counter
//  Description : Row-major x/y scan counter with enable, wrap and a
//                frame-done pulse on the last accepted pixel.
//  Revision    : 1.0 - initial release
// ============================================================================
module lt24_raster_counter #(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320,
    parameter int X_W    = 8,
    parameter int Y_W    = 9
) (
    input  logic           clock,
    input  logic           reset_n_i,
    input  logic           enable_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           frame_done_o
);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           w_last_x;
    logic           w_last_y;

    assign w_last_x = (x_q == X_W'(WIDTH - 1));
    assign w_last_y = (y_q == Y_W'(HEIGHT - 1));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (enable_i) begin
            if (w_last_x) begin
                x_d = '0;
                y_d = w_last_y ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n_i) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o          = x_q;
    assign y_o          = y_q;
    assign frame_done_o = enable_i & w_last_x & w_last_y;

endmodule
`default_nettype wire

// File: rtl/lt24_verdict_screen.sv
`default_nettype none
// ============================================================================
//  Module      : lt24_verdict_screen
//  Description : LT24 raster controller that draws one of NUM_IMAGES ROM
//                images in a scaled window; verdicts switch images only at
//                frame boundaries and fall back to image 0 after HOLD_FRAMES.
//                Define LT24_VERDICT_SCREEN_BORDER_EN for a 2-pixel border
//                around the window while a verdict is shown.
//  Revision    : 1.0 - initial release
// ============================================================================
module lt24_verdict_screen
    import lt24_screen_pkg::*;
#(
    parameter int          LCD_WIDTH    = 240,
    parameter int          LCD_HEIGHT   = 320,
    parameter int          NUM_IMAGES   = 3,
    parameter int          PIC_X_START  = 60,
    parameter int          PIC_Y_START  = 0,
    parameter int          PIC_WIDTH    = 120,
    parameter int          PIC_HEIGHT   = 320,
    parameter int          X_SCALE      = 2,
    parameter int          Y_SCALE      = 1,
    parameter int          HOLD_FRAMES  = 4,
    parameter logic [15:0] BACK_COLOR   = RGB565_BLACK,
    parameter logic [15:0] BORDER_COLOR = RGB565_WHITE,
    localparam int         SEL_W        = (NUM_IMAGES > 1) ? clog2(NUM_IMAGES) : 1,
    localparam int         IMG_W        = PIC_WIDTH / X_SCALE,
    localparam int         IMG_H        = PIC_HEIGHT / Y_SCALE,
    localparam int         ROM_AW       = (IMG_W * IMG_H > 1) ? clog2(IMG_W * IMG_H) : 1
) (
    input  logic              clock,
    input  logic              globalReset_n,
    input  logic              answerValid,
    input  logic [SEL_W-1:0]  answerCode,
    output logic [7:0]        xAddr,
    output logic [8:0]        yAddr,
    output logic [15:0]       pixelData,
    output logic              pixelWrite,
    input  logic              pixelReady,
    output logic [SEL_W-1:0]  romSel,
    output logic [ROM_AW-1:0] romAddr,
    input  logic [15:0]       romData,
    output logic [SEL_W-1:0]  activeImage,
    output logic              frameDone
);

    localparam int              C_XS_SH   = clog2(X_SCALE);
    localparam int              C_YS_SH   = clog2(Y_SCALE);
    localparam int              C_HOLD_W  = (HOLD_FRAMES > 1) ? clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [C_HOLD_W-1:0] C_HOLD = C_HOLD_W'(HOLD_FRAMES);
    localparam logic [SEL_W:0]  C_NUM_IMG = (SEL_W + 1)'(NUM_IMAGES);
    localparam logic [8:0]      C_X_LO    = 9'(PIC_X_START);
    localparam logic [8:0]      C_X_LEN   = 9'(PIC_WIDTH);
    localparam logic [9:0]      C_Y_LO    = 10'(PIC_Y_START);
    localparam logic [9:0]      C_Y_LEN   = 10'(PIC_HEIGHT);
`ifdef LT24_VERDICT_SCREEN_BORDER_EN
    localparam bit              C_BORDER_EN = 1'b1;
`else
    localparam bit              C_BORDER_EN = 1'b0;
`endif

    px_state_e         state_q, state_d;
    mode_state_e       mode_q, mode_d;
    logic [15:0]       pix_q, pix_d;
    logic [SEL_W-1:0]  active_q, active_d;
    logic [SEL_W-1:0]  pend_code_q, pend_code_d;
    logic              pend_vld_q, pend_vld_d;
    logic [C_HOLD_W-1:0] hold_q, hold_d;

    logic [7:0]  w_x;
    logic [8:0]  w_y;
    logic        w_accept;
    logic        w_frame_done;
    logic [8:0]  w_xoff;
    logic [9:0]  w_yoff;
    logic        w_in_win;
    logic        w_on_border;
    logic [15:0] w_pix_sel;

    assign w_accept = (state_q == PX_WRITE) && pixelReady;

    lt24_raster_counter #(
        .WIDTH (LCD_WIDTH),
        .HEIGHT(LCD_HEIGHT),
        .X_W   (8),
        .Y_W   (9)
    ) u_raster (
        .clock       (clock),
        .reset_n_i   (globalReset_n),
        .enable_i    (w_accept),
        .x_o         (w_x),
        .y_o         (w_y),
        .frame_done_o(w_frame_done)
    );

    // Offsets carry one extra bit so a pixel left of/above the window wraps negative.
    assign w_xoff   = {1'b0, w_x} - C_X_LO;
    assign w_yoff   = {1'b0, w_y} - C_Y_LO;
    assign w_in_win = !w_xoff[8] && (w_xoff < C_X_LEN) && !w_yoff[9] && (w_yoff < C_Y_LEN);

    assign w_on_border = (w_xoff < 9'd2) || (w_xoff >= C_X_LEN - 9'd2) ||
                         (w_yoff < 10'd2) || (w_yoff >= C_Y_LEN - 10'd2);

    assign romAddr = w_in_win
                   ? ROM_AW'(32'(w_xoff[7:0] >> C_XS_SH) + 32'(w_yoff[8:0] >> C_YS_SH) * 32'(IMG_W))
                   : '0;

    always_comb begin
        w_pix_sel = romData;
        if (!w_in_win) begin
            w_pix_sel = BACK_COLOR;
        end else if (C_BORDER_EN && (mode_q == MODE_VERDICT) && w_on_border) begin
            w_pix_sel = BORDER_COLOR;
        end
    end

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        case (state_q)
            PX_FETCH: state_d = PX_WAIT;
            PX_WAIT: begin
                state_d = PX_WRITE;
                pix_d   = w_pix_sel;
            end
            PX_WRITE: if (pixelReady) state_d = PX_FETCH;
            default:  state_d = PX_FETCH;
        endcase
    end

    // Boundary decision uses the pending state from before this cycle's trigger.
    always_comb begin
        mode_d      = mode_q;
        active_d    = active_q;
        hold_d      = hold_q;
        pend_vld_d  = pend_vld_q;
        pend_code_d = pend_code_q;
        if (w_frame_done) begin
            if (pend_vld_q) begin
                if (pend_code_q == '0) begin
                    mode_d   = MODE_IDLE;
                    active_d = '0;
                    hold_d   = '0;
                end else begin
                    mode_d   = MODE_VERDICT;
                    active_d = pend_code_q;
                    hold_d   = C_HOLD;
                end
            end else if (mode_q == MODE_VERDICT) begin
                hold_d = hold_q - 1'b1;
                if (hold_q == C_HOLD_W'(1)) begin
                    mode_d   = MODE_IDLE;
                    active_d = '0;
                end
            end
            pend_vld_d = 1'b0;
        end
        if (answerValid && ({1'b0, answerCode} < C_NUM_IMG)) begin
            pend_vld_d  = 1'b1;
            pend_code_d = answerCode;
        end
    end

    always_ff @(posedge clock) begin
        if (!globalReset_n) begin
            state_q     <= PX_FETCH;
            mode_q      <= MODE_IDLE;
            pix_q       <= '0;
            active_q    <= '0;
            pend_vld_q  <= 1'b0;
            pend_code_q <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            pix_q       <= pix_d;
            active_q    <= active_d;
            pend_vld_q  <= pend_vld_d;
            pend_code_q <= pend_code_d;
            hold_q      <= hold_d;
        end
    end

    assign xAddr       = w_x;
    assign yAddr       = w_y;
    assign pixelData   = pix_q;
    assign pixelWrite  = (state_q == PX_WRITE);
    assign romSel      = active_q;
    assign activeImage = active_q;
    assign frameDone   = w_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_lt24_verdict_screen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lt24_verdict_screen
//  Description : Scoreboard bench for lt24_verdict_screen on an 8x4 panel.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lt24_verdict_screen;

    localparam int          W    = 8;
    localparam int          H    = 4;
    localparam int          NI   = 3;
    localparam int          HOLD = 2;
    localparam int          WX0  = 2;
    localparam int          WY0  = 1;
    localparam int          PW   = 4;
    localparam int          PH   = 2;
    localparam logic [15:0] BACK = 16'hABCD;
    localparam logic [15:0] BORD = 16'hFFFF;

    logic        clock = 1'b0;
    logic        globalReset_n = 1'b0;
    logic        answerValid = 1'b0;
    logic [1:0]  answerCode = 2'd0;
    logic        pixelReady = 1'b1;
    logic [7:0]  xAddr;
    logic [8:0]  yAddr;
    logic [15:0] pixelData;
    logic        pixelWrite;
    logic [1:0]  romSel;
    logic [1:0]  romAddr;
    logic [15:0] romData;
    logic [1:0]  activeImage;
    logic        frameDone;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int cnt31    = 0;

    always #5 clock = ~clock;

    lt24_verdict_screen #(
        .LCD_WIDTH(W), .LCD_HEIGHT(H), .NUM_IMAGES(NI),
        .PIC_X_START(WX0), .PIC_Y_START(WY0), .PIC_WIDTH(PW), .PIC_HEIGHT(PH),
        .X_SCALE(2), .Y_SCALE(1), .HOLD_FRAMES(HOLD),
        .BACK_COLOR(BACK), .BORDER_COLOR(BORD)
    ) dut (
        .clock(clock), .globalReset_n(globalReset_n),
        .answerValid(answerValid), .answerCode(answerCode),
        .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData),
        .pixelWrite(pixelWrite), .pixelReady(pixelReady),
        .romSel(romSel), .romAddr(romAddr), .romData(romData),
        .activeImage(activeImage), .frameDone(frameDone)
    );

    // Image ROM bank: each word is {image, address}, one-cycle registered read.
    always @(posedge clock) romData <= {12'h000, romSel, romAddr};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          x;
        int          y;
        logic [15:0] data;
        int          img;
        bit          last;
    } exp_t;

    exp_t sb_q[$];
    int   m_x, m_y, m_img, m_hold, m_pcode;
    bit   m_pend, m_verdict;

    function automatic logic [15:0] exp_pixel(input int x, input int y, input int img, input bit verdict);
        int ox, oy;
        ox = x - WX0;
        oy = y - WY0;
        if (ox < 0 || ox >= PW || oy < 0 || oy >= PH) return BACK;
`ifdef LT24_VERDICT_SCREEN_BORDER_EN
        if (verdict && (ox < 2 || ox >= PW - 2 || oy < 2 || oy >= PH - 2)) return BORD;
`endif
        return 16'(img * 4 + (ox / 2) + oy * (PW / 2));
    endfunction

    always @(negedge clock) begin
        exp_t e;
        #2;
        if (!globalReset_n) begin
            m_x = 0; m_y = 0; m_img = 0; m_hold = 0; m_pcode = 0;
            m_pend = 0; m_verdict = 0;
            sb_q.delete();
        end else begin
            if (pixelWrite && pixelReady) begin
                e.x    = m_x;
                e.y    = m_y;
                e.img  = m_img;
                e.data = exp_pixel(m_x, m_y, m_img, m_verdict);
                e.last = (m_x == W - 1) && (m_y == H - 1);
                sb_q.push_back(e);
                if (e.last) begin
                    m_x = 0; m_y = 0;
                    if (m_pend && m_pcode == 0) begin
                        m_verdict = 0; m_img = 0;
                    end else if (m_pend) begin
                        m_verdict = 1; m_img = m_pcode; m_hold = HOLD;
                    end else if (m_verdict) begin
                        m_hold--;
                        if (m_hold == 0) begin m_verdict = 0; m_img = 0; end
                    end
                    m_pend = 0;
                end else if (m_x == W - 1) begin
                    m_x = 0; m_y++;
                end else begin
                    m_x++;
                end
            end
            if (answerValid && int'(answerCode) < NI) begin
                m_pend = 1; m_pcode = int'(answerCode);
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        exp_t e;
        #3;
        if (globalReset_n) begin
            if (pixelWrite && pixelReady) begin
                wr_cnt++;
                if (xAddr == 8'd3 && yAddr == 9'd1) cnt31++;
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("wr_x", xAddr, e.x);
                    check("wr_y", yAddr, e.y);
                    check("wr_data", pixelData, e.data);
                    check("wr_image", activeImage, e.img);
                    check("wr_romSel", romSel, e.img);
                    check("wr_frameDone", frameDone, e.last);
                end
            end else if (frameDone) begin
                check("frameDone_without_accept", frameDone, 1'b0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_frame_done(output int cycles);
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
        end while (!frameDone && cycles < 2000);
        if (!frameDone) check("frameDone_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_next_image(input string name, input int img);
        int c;
        wait_frame_done(c);
        tick();
        check(name, activeImage, img);
        check({name, "_romSel"}, romSel, img);
    endtask

    task automatic trig(input int code);
        tick();
        answerValid = 1'b1;
        answerCode  = 2'(code);
        tick();
        answerValid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_xAddr"}, xAddr, 0);
        check({tag, "_yAddr"}, yAddr, 0);
        check({tag, "_pixelData"}, pixelData, 0);
        check({tag, "_pixelWrite"}, pixelWrite, 0);
        check({tag, "_romAddr"}, romAddr, 0);
        check({tag, "_romSel"}, romSel, 0);
        check({tag, "_activeImage"}, activeImage, 0);
        check({tag, "_frameDone"}, frameDone, 0);
    endtask

    task automatic first_write_latency(input string name);
        int c;
        c = 0;
        do begin
            tick();
            c++;
        end while (!pixelWrite && c < 10);
        check(name, c, 2);
    endtask

    initial begin
        int c;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_values("por");
        tick();
        globalReset_n = 1'b1;
        first_write_latency("first_write_latency");

        // frame 0: write count, then frame period with pixelReady high
        wr_cnt = 0;
        wait_frame_done(c);
        tick();
        check("frame0_writes", wr_cnt, 32);
        wait_frame_done(c);
        check("frame_period", c, 96);
        tick();

        // verdict 2 shown for exactly HOLD frames, with a stall in the first
        repeat (20) tick();
        trig(2);
        expect_next_image("t2_frame1", 2);
        repeat (10) tick();
        cnt31 = 0;
        c = 0;
        do begin
            @(negedge clock);
            c++;
        end while (!(!pixelWrite && xAddr == 8'd3 && yAddr == 9'd1) && c < 500);
        #1 pixelReady = 1'b0;
        c = 0;
        do begin
            @(negedge clock);
            c++;
        end while (!pixelWrite && c < 10);
        check("stall_write_up", pixelWrite, 1);
        check("stall_data", pixelData, 16'h0008);
        repeat (4) begin
            @(negedge clock);
            check("stall_write_held", pixelWrite, 1);
            check("stall_data_held", pixelData, 16'h0008);
            check("stall_x_held", xAddr, 3);
        end
        tick();
        pixelReady = 1'b1;
        expect_next_image("t2_frame2", 2);
        check("stall_single_write", cnt31, 1);
        expect_next_image("t2_frame3_idle", 0);

        // newest trigger wins; out-of-range code ignored
        repeat (10) tick();
        trig(1);
        trig(2);
        expect_next_image("t4_last_wins", 2);
        repeat (10) tick();
        trig(3);
        expect_next_image("t4_code3_ignored", 2);

        // code 0 ends a verdict early; trigger on the frameDone cycle is deferred
        repeat (10) tick();
        trig(1);
        expect_next_image("t5_verdict1", 1);
        repeat (10) tick();
        trig(0);
        expect_next_image("t5_code0_idle", 0);
        c = 0;
        do begin
            @(negedge clock);
            c++;
        end while (!(pixelWrite && xAddr == 8'd7 && yAddr == 9'd3) && c < 500);
        check("t5_fd_cycle", frameDone, 1);
        #1;
        answerValid = 1'b1;
        answerCode  = 2'd2;
        @(posedge clock);
        #1;
        answerValid = 1'b0;
        check("t5_deferred", activeImage, 0);
        expect_next_image("t5_applied", 2);

        // one-cycle reset mid-frame during a verdict
        repeat (15) tick();
        globalReset_n = 1'b0;
        tick();
        check_reset_values("mid_reset");
        globalReset_n = 1'b1;
        first_write_latency("reset_first_write_latency");
        check("reset_first_x", xAddr, 0);
        check("reset_first_y", yAddr, 0);
        check("reset_first_image", activeImage, 0);

        // randomized backpressure and triggers, checked by the scoreboard
        repeat (1500) begin
            tick();
            pixelReady = ($urandom_range(3) != 0);
            if ($urandom_range(29) == 0) begin
                answerValid = 1'b1;
                answerCode  = 2'($urandom_range(3));
            end else begin
                answerValid = 1'b0;
            end
        end
        pixelReady  = 1'b1;
        answerValid = 1'b0;
        repeat (5) tick();
        check("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, expected finish before %0t", $time);
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire

// File: doc/lt24_verdict_screen.md
# lt24_verdict_screen

Parametrised LT24 image-selection controller feeding the `LT24Display` pixel interface, generalising the quiz big-screen to N stored images. It raster-scans the full panel, fetches picture-window pixels from an external image ROM bank, with optional horizontal and vertical pixel replication, and fills everything outside the window with a background colour. Verdict triggers are queued and applied only at frame boundaries, so frames never tear. Each verdict image is shown for a fixed number of frames, then the block returns to the idle image (image 0).

## Interface
- `LCD_WIDTH`, 240, panel columns
- `LCD_HEIGHT`, 320, panel rows
- `NUM_IMAGES`, 3, stored images; image 0 = idle
- `PIC_X_START`, 60, first window column
- `PIC_Y_START`, 0, first window row
- `PIC_WIDTH`, 120, window width in panel pixels
- `PIC_HEIGHT`, 320, window height in panel pixels
- `X_SCALE`, 2, horizontal replication factor (power of two)
- `Y_SCALE`, 1, vertical replication factor (power of two)
- `HOLD_FRAMES`, 4, frames a verdict image stays up (≥1)
- `BACK_COLOR`, 16'h0000, RGB565 fill outside the window
- `BORDER_COLOR`, 16'hFFFF, RGB565 border colour (used only with the border feature)
- `clock` in 1: the single clock
- `globalReset_n` in 1: synchronous, active-low reset
- `answerValid` in 1: one-cycle verdict trigger
- `answerCode` in SEL_W: requested image, SEL_W = max(1, clog2(NUM_IMAGES))
- `xAddr` out 8: current pixel column
- `yAddr` out 9: current pixel row
- `pixelData` out 16: RGB565 pixel
- `pixelWrite` out 1: pixel valid
- `pixelReady` in 1: display has accepted the pixel
- `romSel` out SEL_W: image select to the ROM bank
- `romAddr` out ROM_AW: ROM word address, ROM_AW = clog2(IMG_W*IMG_H)
- `romData` in 16: ROM read data, registered, 1-cycle latency
- `activeImage` out SEL_W: image being drawn this frame
- `frameDone` out 1: one-cycle pulse after the last pixel of a frame is accepted

## Operation
- IMG_W = PIC_WIDTH/X_SCALE and IMG_H = PIC_HEIGHT/Y_SCALE. Each image is stored row-major with stride IMG_W.
- Pixel FSM states: FETCH, WAIT, WRITE.
  - FETCH: if (x,y) is inside the window, drive romAddr = ((x−PIC_X_START)>>log2 X_SCALE) + ((y−PIC_Y_START)>>log2 Y_SCALE)·IMG_W. Otherwise drive romAddr = 0.
  - WAIT: romData becomes valid.
  - WRITE: pixelWrite = 1. pixelData = romData inside the window, BACK_COLOR outside. Hold both until the cycle in which pixelReady = 1.
- On acceptance, x increments. At x = LCD_WIDTH−1, x wraps to 0 and y increments. At (LCD_WIDTH−1, LCD_HEIGHT−1), both wrap to 0 and frameDone pulses. The FSM then returns to FETCH.
- Mode FSM states: IDLE (activeImage = 0), VERDICT (activeImage = latched code, holdCnt counting).
- A trigger with answerValid = 1 and answerCode < NUM_IMAGES is written to `pending`. A newer trigger overwrites an older one. Codes ≥ NUM_IMAGES are ignored.
- At each frame boundary (the cycle frameDone is asserted), in priority order:
  1. pending code = 0: go to IDLE.
  2. Other pending code: go to VERDICT with that image and set holdCnt = HOLD_FRAMES.
  3. No pending code, in VERDICT: decrement holdCnt; on reaching 0, go to IDLE.
  4. Clear pending.
- A trigger in the same cycle as frameDone is queued for the next boundary, not the current one.
- romSel always equals activeImage. activeImage changes only at frame boundaries.

## Timing
- Reset values: xAddr = 0, yAddr = 0, pixelData = 0, pixelWrite = 0, romAddr = 0, romSel = 0, activeImage = 0, frameDone = 0. Reset also sets FSM = FETCH, mode = IDLE, pending empty, holdCnt = 0.
- First pixelWrite rises 2 cycles after globalReset_n is released.
- Minimum 3 cycles per pixel; each cycle pixelReady is low adds one.
- Reset asserted mid-frame or mid-WRITE aborts the pixel in the next cycle. Drawing restarts at (0,0) with image 0.
- A verdict image is visible for exactly HOLD_FRAMES complete frames.

## Configuration
- `LT24_VERDICT_SCREEN_BORDER_EN` defined: while in VERDICT, window pixels on the outermost 2 rows and columns output BORDER_COLOR instead of romData. ROM is still read, so timing is unchanged.
- Not defined: no border logic; window pixels are always romData.

## Structure
- Shared package `lt24_screen_pkg`:
  - RGB565 colour constants
  - pixel-FSM state enum
  - mode state enum
  - `clog2` helper
- Sub-module `lt24_raster_counter`: x/y scan counter with enable, wrap and frameDone generation. It is a parametrised replacement for the paired up-counters.

## Test plan
Bench parameters: LCD 8×4, window X 2..5, Y 1..2, X_SCALE 2, Y_SCALE 1, HOLD_FRAMES 2, NUM_IMAGES 3, ROM word = {image, address}.
1. Reset, pixelReady tied 1 → first frame gives 32 writes. Pixel (2,1) = {0,0}, (4,2) = {0,3}, (0,0) = BACK_COLOR. frameDone pulses once every 96 cycles.
2. answerCode = 2 mid-frame 0 → frames 1 and 2 are drawn with activeImage = 2, frame 3 with activeImage = 0.
3. pixelReady low for 5 cycles during WRITE at (3,1) → pixelData and pixelWrite held stable; exactly one write is recorded for (3,1).
4. Code 1 then code 2 in the same frame → only image 2 is shown next frame. Code 3 → ignored, activeImage unchanged.
5. Code 0 during VERDICT → IDLE at the next boundary. A trigger on the frameDone cycle → applied one frame later.
6. globalReset_n low for 1 cycle mid-frame in VERDICT → all outputs return to reset values; the next write is at (0,0) with image 0.
